ika9958_status_reader: RTL

- CPU-side read end of the VDP status flags. Video-engine blocks raise sticky flags with single-tick set pulses; this block holds them and returns status register S#n on a port #1 read.
- Flags that the hardware clears on read are cleared when the CPU read ends.
- Also generates the registered interrupt output.
- Sits between the timing/sprite engines and the CPU bus mux.

---
 rtl/ika9958_status_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ika9958_status_reader.sv
// CPU-side status register reader for the VDP: holds sticky event flags, returns S#n on a
// port #1 read, clears read-sensitive flags when the read ends, and drives the interrupt.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for synchronized RD_n low; snapshot taken on exit
// ST_READ  | read in progress, o_DO held, waiting for RD_n high
// ST_CLEAR | one tick applying the read-side clear for the captured pointer
module ika9958_status_reader #(
  parameter int         RD_SYNC = 2,
  parameter logic [4:0] CHIP_ID = 5'd2
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_CEN,
  input  logic       i_RD_n,
  input  logic [3:0] i_STSEL,
  input  logic       i_IE0,
  input  logic       i_IE1,
  input  logic       i_VBLANK_SET,
  input  logic       i_HLINE_SET,
  input  logic       i_COL_SET,
  input  logic [8:0] i_COL_X,
  input  logic [9:0] i_COL_Y,
  input  logic       i_FIFTH_SET,
  input  logic [4:0] i_FIFTH_NUM,
  input  logic [7:0] i_LIVE,
  input  logic [7:0] i_CLR,
  output logic [7:0] o_DO,
  output logic       o_DOE,
  output logic       o_INT_n
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CLEAR} state_t;

  state_t             state_q, state_d;
  logic [RD_SYNC-1:0] rd_sync_q, rd_sync_d;
  logic [3:0]         stsel_q, stsel_d;
  logic               f_q, f_d, fh_q, fh_d, c_q, c_d, s5_q, s5_d;
  logic [4:0]         fifth_num_q, fifth_num_d;
  logic [8:0]         colx_q, colx_d;
  logic [9:0]         coly_q, coly_d;
  logic               lock_q, lock_d;
  logic [7:0]         do_q, do_d;
  logic               doe_q, doe_d, int_n_q, int_n_d;
  logic               rd_s;
  logic [7:0]         snap;

  assign rd_s = rd_sync_q[RD_SYNC-1];

  always_comb begin
    snap = 8'hFF;
    case (i_STSEL)
      4'd0:    snap = {f_q, s5_q, c_q, fifth_num_q};
      4'd1:    snap = {2'b00, CHIP_ID, fh_q};
      4'd2:    snap = i_LIVE;
      4'd3:    snap = colx_q[7:0];
      4'd4:    snap = {7'h7F, colx_q[8]};
      4'd5:    snap = coly_q[7:0];
      4'd6:    snap = {6'h3F, coly_q[9:8]};
      4'd7:    snap = i_CLR;
      4'd8:    snap = 8'h00;
      4'd9:    snap = 8'h00;
      default: snap = 8'hFF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_sync_d   = rd_sync_q;
    stsel_d     = stsel_q;
    f_d         = f_q;
    fh_d        = fh_q;
    c_d         = c_q;
    s5_d        = s5_q;
    fifth_num_d = fifth_num_q;
    colx_d      = colx_q;
    coly_d      = coly_q;
    lock_d      = lock_q;
    do_d        = do_q;
    doe_d       = doe_q;
    int_n_d     = int_n_q;
    if (i_CEN) begin
      rd_sync_d[0] = i_RD_n;
      for (int i = 1; i < RD_SYNC; i++) rd_sync_d[i] = rd_sync_q[i-1];

      case (state_q)
        ST_IDLE: if (!rd_s) begin
          state_d = ST_READ;
          do_d    = snap;
          doe_d   = 1'b1;
          stsel_d = i_STSEL;
        end
        ST_READ: if (rd_s) begin
          state_d = ST_CLEAR;
          doe_d   = 1'b0;
        end
        ST_CLEAR: begin
          state_d = ST_IDLE;
          case (stsel_q)
            4'd0: begin f_d = 1'b0; s5_d = 1'b0; c_d = 1'b0; end
            4'd1: fh_d = 1'b0;
            4'd5: lock_d = 1'b0;
            default: ;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase

      // Sets are applied after clears and test the post-clear value, so a pulse
      // landing on the clear tick is never lost.
      if (i_VBLANK_SET) f_d = 1'b1;
      if (i_HLINE_SET)  fh_d = 1'b1;
      if (i_FIFTH_SET && !s5_d) begin
        s5_d        = 1'b1;
        fifth_num_d = i_FIFTH_NUM;
      end
      if (i_COL_SET) begin
        c_d = 1'b1;
        if (!lock_d) begin
          colx_d = i_COL_X;
          coly_d = i_COL_Y;
          lock_d = 1'b1;
        end
      end

      int_n_d = ~((f_q & i_IE0) | (fh_q & i_IE1));
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= ST_IDLE;
      rd_sync_q   <= '1;
      stsel_q     <= 4'd0;
      f_q         <= 1'b0;
      fh_q        <= 1'b0;
      c_q         <= 1'b0;
      s5_q        <= 1'b0;
      fifth_num_q <= 5'd0;
      colx_q      <= 9'd0;
      coly_q      <= 10'd0;
      lock_q      <= 1'b0;
      do_q        <= 8'h00;
      doe_q       <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_sync_q   <= rd_sync_d;
      stsel_q     <= stsel_d;
      f_q         <= f_d;
      fh_q        <= fh_d;
      c_q         <= c_d;
      s5_q        <= s5_d;
      fifth_num_q <= fifth_num_d;
      colx_q      <= colx_d;
      coly_q      <= coly_d;
      lock_q      <= lock_d;
      do_q        <= do_d;
      doe_q       <= doe_d;
      int_n_q     <= int_n_d;
    end
  end

  assign o_DO    = do_q;
  assign o_DOE   = doe_q;
  assign o_INT_n = int_n_q;

endmodule
